// File: rtl/memoria_pkg.sv
// memoria_pkg: copy FSM state type and address/bank width helper shared by the memoria files
package memoria_pkg;
  typedef enum logic [1:0] {IDLE, COPY, FIN} state_t;
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/memoria_banks_copy_if.sv
// memoria_banks_copy_if: port A/B read-write buses plus copy start/src/dst/busy/done; master drives requests, slave is the memory
interface memoria_banks_copy_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NBANKS = 2
);
  import memoria_pkg::*;
  localparam int AW = width_of(DEPTH);
  localparam int BW = width_of(NBANKS);
  logic we_a, re_a, we_b, re_b;
  logic [BW-1:0] bank_a, bank_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [WIDTH-1:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic copy_start, busy, done;
  logic [BW-1:0] copy_src, copy_dst;
  modport master (
    output we_a, re_a, bank_a, addr_a, wdata_a, we_b, re_b, bank_b, addr_b, wdata_b,
    output copy_start, copy_src, copy_dst,
    input rdata_a, rdata_b, busy, done
  );
  modport slave (
    input we_a, re_a, bank_a, addr_a, wdata_a, we_b, re_b, bank_b, addr_b, wdata_b,
    input copy_start, copy_src, copy_dst,
    output rdata_a, rdata_b, busy, done
  );
endinterface

// File: rtl/memoria_copy_fsm.sv
// memoria_copy_fsm: bank copy sequencer (copy_start/src/dst in; busy, done, copy write strobe cwe with caddr/csrc/cdst out)
module memoria_copy_fsm import memoria_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int NBANKS = 2,
  localparam int AW = width_of(DEPTH),
  localparam int BW = width_of(NBANKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          copy_start,
  input  logic [BW-1:0] copy_src,
  input  logic [BW-1:0] copy_dst,
  output logic          busy,
  output logic          done,
  output logic          cwe,
  output logic [AW-1:0] caddr,
  output logic [BW-1:0] csrc,
  output logic [BW-1:0] cdst
);
  localparam logic [BW:0] NB = (BW+1)'(NBANKS);
  state_t state, nxt;
  logic [AW-1:0] cnt;
  logic [BW-1:0] src, dst;
  logic skip, last;
  always_comb begin
    skip = copy_src == copy_dst || {1'b0, copy_src} >= NB || {1'b0, copy_dst} >= NB;
    last = cnt == AW'(DEPTH - 1);
    nxt = (state == IDLE) ? (copy_start ? (skip ? FIN : COPY) : IDLE)
        : (state == COPY) ? (last ? FIN : COPY) : IDLE;
    busy = state == COPY;
    done = state == FIN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      src <= '0;
      dst <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && copy_start) begin
        src <= copy_src;
        dst <= copy_dst;
        cnt <= '0;
      end else if (state == COPY) cnt <= cnt + AW'(1);
    end
  assign cwe = busy;
  assign caddr = cnt;
  assign csrc = src;
  assign cdst = dst;
endmodule

// File: rtl/memoria_banks_copy.sv
// memoria_banks_copy: NBANKS x DEPTH x WIDTH memory, two registered read/write ports and a bank copy engine (clk, reset, bus slave)
module memoria_banks_copy import memoria_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NBANKS = 2,
  localparam int AW = width_of(DEPTH),
  localparam int BW = width_of(NBANKS)
) (
  input logic clk,
  input logic reset,
  memoria_banks_copy_if.slave bus
);
  localparam logic [BW:0] NB = (BW+1)'(NBANKS);
  logic [WIDTH-1:0] mem [NBANKS][DEPTH];
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic busy, done, cwe, ok_a, ok_b, wr_a, wr_b;
  logic [AW-1:0] caddr;
  logic [BW-1:0] csrc, cdst;
  memoria_copy_fsm #(.DEPTH(DEPTH), .NBANKS(NBANKS)) u_fsm (
    .clk(clk), .reset(reset), .copy_start(bus.copy_start), .copy_src(bus.copy_src),
    .copy_dst(bus.copy_dst), .busy(busy), .done(done), .cwe(cwe), .caddr(caddr),
    .csrc(csrc), .cdst(cdst)
  );
  always_comb begin
    ok_a = {1'b0, bus.bank_a} < NB;
    ok_b = {1'b0, bus.bank_b} < NB;
    wr_a = bus.we_a && ok_a && !(busy && bus.bank_a == cdst);
    wr_b = bus.we_b && ok_b && !(busy && bus.bank_b == cdst);
  end
  // port B is written before port A so A wins a same-word collision
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < NBANKS; i++)
        for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (bus.re_a) rdata_a <= ok_a ? mem[bus.bank_a][bus.addr_a] : '0;
      if (bus.re_b) rdata_b <= ok_b ? mem[bus.bank_b][bus.addr_b] : '0;
      if (wr_b) mem[bus.bank_b][bus.addr_b] <= bus.wdata_b;
      if (wr_a) mem[bus.bank_a][bus.addr_a] <= bus.wdata_a;
      if (cwe) mem[cdst][caddr] <= mem[csrc][caddr];
    end
  assign bus.rdata_a = rdata_a;
  assign bus.rdata_b = rdata_b;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
